// File: rtl/nn_sequencer_if.sv
// Handshake bundle between the NN control sequencer and the image RAM / compute engines.
// The sequencer takes the master side; the engines and the bench take the slave side.
interface nn_sequencer_if;
  logic       start;
  logic       train_mode;
  logic       fwd_done;
  logic       bwd_done;
  logic       upd_done;
  logic [3:0] pred;
  logic [3:0] label;
  logic [2:0] curr_state;
  logic       fwd_start;
  logic       bwd_start;
  logic       upd_start;
  logic [8:0] img_idx;
  logic [9:0] correct_cnt;
  logic       busy;
  logic       done;

  modport master (
    input  start, train_mode, fwd_done, bwd_done, upd_done, pred, label,
    output curr_state, fwd_start, bwd_start, upd_start, img_idx, correct_cnt, busy, done
  );

  modport slave (
    output start, train_mode, fwd_done, bwd_done, upd_done, pred, label,
    input  curr_state, fwd_start, bwd_start, upd_start, img_idx, correct_cnt, busy, done
  );
endinterface

// File: rtl/nn_sequencer.sv
// Control FSM for one pass over the stored images: load, wait for RAM, forward, optional backprop/update.
// All outputs are registered; engine done pulses are honoured only after their launch cycle.
module nn_sequencer #(
  parameter int NUM_IMAGES  = 512,
  parameter int RAM_LATENCY = 2,
  parameter int CLASSES     = 10
) (
  input  logic          clk,
  input  logic          rst,
  nn_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_LOAD = 3'b001,
    S_WAIT = 3'b010,
    S_FWD  = 3'b011,
    S_BWD  = 3'b100,
    S_UPD  = 3'b101,
    S_DONE = 3'b110
  } state_t;

  localparam int             WCW       = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(RAM_LATENCY - 1);
  localparam logic [8:0]     LAST_IMG  = 9'(NUM_IMAGES - 1);

  if (CLASSES < 1 || CLASSES > 16) begin : g_bad_classes
    $error("nn_sequencer: CLASSES must fit the 4-bit pred/label encoding");
  end

  state_t         state_q, state_d;
  logic           train_q, train_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [8:0]     img_idx_q, img_idx_d;
  logic [9:0]     correct_q, correct_d;
  logic           fwd_start_q, fwd_start_d;
  logic           bwd_start_q, bwd_start_d;
  logic           upd_start_q, upd_start_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           advance;

  always_comb begin
    state_d     = state_q;
    train_d     = train_q;
    wcnt_d      = wcnt_q;
    img_idx_d   = img_idx_q;
    correct_d   = correct_q;
    fwd_start_d = 1'b0;
    bwd_start_d = 1'b0;
    upd_start_d = 1'b0;
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          train_d   = bus.train_mode;
          correct_d = '0;
          img_idx_d = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          state_d     = S_FWD;
          fwd_start_d = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      // A start flop still high marks the launch cycle, where a done pulse is stale.
      S_FWD: begin
        if (bus.fwd_done && !fwd_start_q) begin
          if (train_q) begin
            state_d     = S_BWD;
            bwd_start_d = 1'b1;
          end else begin
            if (bus.pred == bus.label) begin
              correct_d = correct_q + 10'd1;
            end
            advance = 1'b1;
          end
        end
      end
      S_BWD: begin
        if (bus.bwd_done && !bwd_start_q) begin
          state_d     = S_UPD;
          upd_start_d = 1'b1;
        end
      end
      S_UPD: begin
        if (bus.upd_done && !upd_start_q) begin
          advance = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance) begin
      if (img_idx_q == LAST_IMG) begin
        state_d = S_DONE;
      end else begin
        img_idx_d = img_idx_q + 9'd1;
        state_d   = S_LOAD;
      end
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      train_q     <= 1'b0;
      wcnt_q      <= '0;
      img_idx_q   <= '0;
      correct_q   <= '0;
      fwd_start_q <= 1'b0;
      bwd_start_q <= 1'b0;
      upd_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      train_q     <= train_d;
      wcnt_q      <= wcnt_d;
      img_idx_q   <= img_idx_d;
      correct_q   <= correct_d;
      fwd_start_q <= fwd_start_d;
      bwd_start_q <= bwd_start_d;
      upd_start_q <= upd_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.curr_state  = state_q;
  assign bus.fwd_start   = fwd_start_q;
  assign bus.bwd_start   = bwd_start_q;
  assign bus.upd_start   = upd_start_q;
  assign bus.img_idx     = img_idx_q;
  assign bus.correct_cnt = correct_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_nn_sequencer.sv
// Randomized bench for nn_sequencer: engine responders plus a per-image state-trace and score model.
// Expected traces are built from per-image phase lengths; noise done/start pulses probe the ignore rules.
module tb_nn_sequencer;
  localparam int N  = 4;
  localparam int RL = 2;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_WAIT = 3'd2, ST_FWD = 3'd3,
                         ST_BWD  = 3'd4, ST_UPD  = 3'd5, ST_DONE = 3'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  nn_sequencer_if bus();

  nn_sequencer #(.NUM_IMAGES(N), .RAM_LATENCY(RL), .CLASSES(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int fd[N], bd[N], ud[N], pr[N], lb[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    bus.start      = 1'b0;
    bus.train_mode = 1'b0;
    bus.fwd_done   = 1'b0;
    bus.bwd_done   = 1'b0;
    bus.upd_done   = 1'b0;
    bus.pred       = 4'd0;
    bus.label      = 4'd0;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_state"},   bus.curr_state, ST_IDLE);
    chk({pfx, "_idx"},     bus.img_idx, 0);
    chk({pfx, "_correct"}, bus.correct_cnt, 0);
    chk({pfx, "_starts"},  {bus.fwd_start, bus.bwd_start, bus.upd_start}, 0);
    chk({pfx, "_busy"},    bus.busy, 0);
    chk({pfx, "_done"},    bus.done, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
  endtask

  task automatic run_pass(input bit tm, input int abort_img, output bit aborted);
    int loads = 0, img = 0, fcnt = -1, bcnt = -1, ucnt = -1;
    int nfs = 0, nbs = 0, nus = 0, done_cyc = 0, exp_correct = 0;
    bit finished = 0, fwd_real, bwd_real, upd_real;
    logic [2:0] st, prev;
    int obs_st[$], obs_len[$], exp_st[$], exp_len[$];
    aborted = 0;

    // Stray done pulses while idle must not move the FSM.
    repeat (2) begin
      bus.fwd_done = 1'($urandom); bus.bwd_done = 1'($urandom); bus.upd_done = 1'($urandom);
      @(posedge clk); #1;
      chk("idle_hold", bus.curr_state, ST_IDLE);
    end
    drive_idle();
    bus.start = 1'b1;
    bus.train_mode = tm;
    @(posedge clk); #1;
    bus.start = 1'b0;
    prev = ST_IDLE;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      st = bus.curr_state;
      if (obs_st.size() == 0 || obs_st[obs_st.size()-1] != int'(st)) begin
        obs_st.push_back(int'(st)); obs_len.push_back(1);
      end else begin
        obs_len[obs_len.size()-1] += 1;
      end
      if (st == ST_LOAD) begin loads++; img = loads - 1; end

      chk("img_idx",   bus.img_idx, img);
      chk("busy",      bus.busy, (st != ST_IDLE && st != ST_DONE));
      chk("done",      bus.done, (st == ST_DONE));
      chk("fwd_start", bus.fwd_start, (st == ST_FWD && prev != ST_FWD));
      chk("bwd_start", bus.bwd_start, (st == ST_BWD && prev != ST_BWD));
      chk("upd_start", bus.upd_start, (st == ST_UPD && prev != ST_UPD));
      if (bus.fwd_start) nfs++;
      if (bus.bwd_start) nbs++;
      if (bus.upd_start) nus++;

      if (abort_img >= 0 && st == ST_BWD && img == abort_img && !bus.bwd_start) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("abort");
        rst = 1'b0;
        drive_idle();
        aborted = 1;
        break;
      end
      if (st == ST_DONE) begin
        done_cyc++;
        if (done_cyc == 4) begin finished = 1; break; end
      end

      img = (img < N) ? img : N - 1;
      fwd_real = 0; bwd_real = 0; upd_real = 0;
      if (bus.fwd_start) fcnt = fd[img];
      else if (fcnt > 0) begin fcnt--; if (fcnt == 0) begin fwd_real = 1; fcnt = -1; end end
      if (bus.bwd_start) bcnt = bd[img];
      else if (bcnt > 0) begin bcnt--; if (bcnt == 0) begin bwd_real = 1; bcnt = -1; end end
      if (bus.upd_start) ucnt = ud[img];
      else if (ucnt > 0) begin ucnt--; if (ucnt == 0) begin upd_real = 1; ucnt = -1; end end

      bus.fwd_done = fwd_real | bus.fwd_start | (st != ST_FWD && $urandom_range(3) == 0);
      bus.bwd_done = bwd_real | bus.bwd_start | bus.fwd_start | (st != ST_BWD && $urandom_range(3) == 0);
      bus.upd_done = upd_real | bus.upd_start | (st != ST_UPD && $urandom_range(3) == 0);
      if (fwd_real) begin
        bus.pred = 4'(pr[img]); bus.label = 4'(lb[img]);
      end else begin
        bus.pred = 4'($urandom_range(9)); bus.label = bus.pred;
      end
      bus.start      = (st == ST_DONE) ? 1'b1 : ($urandom_range(3) == 0);
      bus.train_mode = 1'($urandom);
      prev = st;
      @(posedge clk); #1;
    end

    if (!aborted) begin
      drive_idle();
      if (!finished) chk("timeout", 0, 1);
      for (int i = 0; i < N; i++) begin
        exp_st.push_back(ST_LOAD); exp_len.push_back(1);
        exp_st.push_back(ST_WAIT); exp_len.push_back(RL);
        exp_st.push_back(ST_FWD);  exp_len.push_back(fd[i] + 1);
        if (tm) begin
          exp_st.push_back(ST_BWD); exp_len.push_back(bd[i] + 1);
          exp_st.push_back(ST_UPD); exp_len.push_back(ud[i] + 1);
        end else if (pr[i] == lb[i]) begin
          exp_correct++;
        end
      end
      exp_st.push_back(ST_DONE); exp_len.push_back(4);

      chk("trace_runs", obs_st.size(), exp_st.size());
      for (int i = 0; i < exp_st.size() && i < obs_st.size(); i++) begin
        chk($sformatf("trace_state%0d", i), obs_st[i], exp_st[i]);
        chk($sformatf("trace_len%0d", i), obs_len[i], exp_len[i]);
      end
      chk("load_cycles", loads, N);
      chk("n_fwd",       nfs, N);
      chk("n_bwd",       nbs, tm ? N : 0);
      chk("n_upd",       nus, tm ? N : 0);
      chk("correct_cnt", bus.correct_cnt, exp_correct);
      chk("final_idx",   bus.img_idx, N - 1);
    end
  endtask

  initial begin
    bit ab;
    drive_idle();
    do_reset();

    pr = '{3, 1, 7, 2};
    lb = '{3, 5, 7, 2};
    for (int i = 0; i < N; i++) begin fd[i] = i + 1; bd[i] = 5; ud[i] = 5; end
    run_pass(1'b0, -1, ab);
    chk("dir_correct3", bus.correct_cnt, 3);

    do_reset();
    for (int i = 0; i < N; i++) begin fd[i] = 5; bd[i] = 5; ud[i] = 5; end
    run_pass(1'b1, -1, ab);
    chk("train_correct0", bus.correct_cnt, 0);

    do_reset();
    run_pass(1'b1, 3, ab);
    chk("aborted", ab, 1);
    run_pass(1'b0, -1, ab);

    for (int p = 0; p < 6; p++) begin
      do_reset();
      for (int i = 0; i < N; i++) begin
        fd[i] = $urandom_range(6, 1);
        bd[i] = $urandom_range(6, 1);
        ud[i] = $urandom_range(6, 1);
        pr[i] = $urandom_range(9);
        lb[i] = ($urandom_range(1) == 1) ? pr[i] : $urandom_range(9);
      end
      run_pass(1'($urandom_range(1)), -1, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/nn_sequencer.md
Name: nn_sequencer

Overview:
- Top-level control FSM for the FPGA neural-network datapath.
- Drives the 3-bit `curr_state` bus consumed by the image RAM wrapper. That wrapper advances its image pointer on every cycle `curr_state == 3'b001`; its pointer resets to 511, so the first advance selects image 0.
- Runs one pass over the stored images. For each image it:
  - issues one advance, then waits out the RAM read latency;
  - launches forward propagation;
  - in train mode, also launches backward propagation and the weight update;
  - in classify mode, scores the prediction against the label.
- Reports progress and the correct-classification count.

Parameters:
- NUM_IMAGES, 512, images per pass (1..512).
- RAM_LATENCY, 2, cycles from the LOAD cycle until `image` data is valid (≥1).
- CLASSES, 10, number of output classes. `label` and `pred` are 4 bits wide, so CLASSES ≤ 16.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a pass. Honoured only in IDLE.
- train_mode  in  1  1 = train, 0 = classify. Sampled when `start` is accepted.
- fwd_done  in  1  one-cycle pulse from the forward engine.
- bwd_done  in  1  one-cycle pulse from the backprop engine.
- upd_done  in  1  one-cycle pulse from the weight-update engine.
- pred  in  4  predicted class. Valid in the `fwd_done` cycle.
- label  in  4  label of the current image. Valid in the `fwd_done` cycle.
- curr_state  out  3  state encoding, fed to the image RAM.
- fwd_start  out  1  one-cycle launch pulse.
- bwd_start  out  1  one-cycle launch pulse.
- upd_start  out  1  one-cycle launch pulse.
- img_idx  out  9  index of the image being processed.
- correct_cnt  out  10  number of correct classifications in this pass.
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset: all outputs are registered and clear to 0 on the clock edge with `rst` high.
  - This gives curr_state = IDLE, img_idx = 0, correct_cnt = 0, all start pulses 0, busy = 0, done = 0.
  - A reset mid-pass aborts immediately. Engines receive no further start pulses.
  - The image RAM is reset by the same `rst`, so image pointers stay aligned.
- State encodings: IDLE = 000, LOAD = 001, WAIT = 010, FWD = 011, BWD = 100, UPD = 101, DONE = 110. The unused code 111 goes to IDLE on the next cycle.
- The latched train mode is held in an internal register for the whole pass; the `train_mode` input is ignored after `start` is accepted.
- IDLE:
  - With `start` = 1: latch `train_mode`, clear correct_cnt and img_idx, then go to LOAD.
  - Otherwise stay in IDLE.
- LOAD: lasts exactly one cycle (this is the single pointer advance), then WAIT.
- WAIT: lasts RAM_LATENCY cycles, counted by an internal counter, then FWD.
- FWD:
  - fwd_start is high in the first FWD cycle only.
  - fwd_done is honoured only from the second FWD cycle onward. A `fwd_done` coincident with `fwd_start` is ignored.
  - On an honoured `fwd_done` in train mode: go to BWD.
  - On an honoured `fwd_done` in classify mode: correct_cnt increments when pred == label, then advance (see below).
- BWD: bwd_start is high in the first cycle only; `bwd_done` is honoured from the second cycle. On `bwd_done`, go to UPD.
- UPD: upd_start is high in the first cycle only; `upd_done` is honoured from the second cycle. On `upd_done`, advance.
- Advance:
  - If img_idx == NUM_IMAGES-1: go to DONE, holding img_idx.
  - Otherwise: img_idx increments and the FSM goes to LOAD. The back-to-back LOAD has no idle cycle.
- Ignored inputs:
  - `*_done` pulses in any state other than the matching one.
  - `start` in any state other than IDLE.
- DONE:
  - Terminal state; only `rst` leaves it.
  - The image RAM pointer is not rewound by this block, so a new pass requires reset.
  - correct_cnt and img_idx hold their values.
- Widths:
  - correct_cnt is 10 bits and cannot overflow, since at most 512 increments occur.
  - img_idx never exceeds NUM_IMAGES-1.
- Exactly one LOAD cycle occurs per image, so the pointer advances once per image.

Test Plan:
- Reset, then `start` = 1 with train_mode = 0 for one cycle → next cycle curr_state = 001 for exactly 1 cycle, then 010 for 2 cycles, then 011 with fwd_start = 1 for 1 cycle; img_idx = 0.
- Classify, NUM_IMAGES = 4, preds [3,1,7,2] vs labels [3,5,7,2] → DONE reached with correct_cnt = 3, img_idx = 3, done = 1, busy = 0; exactly 4 LOAD cycles counted.
- Train, NUM_IMAGES = 2, engines answer 5 cycles after each start → per image the sequence FWD → BWD → UPD with one start pulse each; correct_cnt = 0; DONE after image 1.
- `fwd_done` asserted in the same cycle as fwd_start, and `bwd_done` asserted in FWD → both ignored; the FSM stays in FWD until the next `fwd_done`.
- `rst` asserted while in BWD on image 3 → next cycle curr_state = 000, img_idx = 0, correct_cnt = 0; a subsequent `start` produces a LOAD for image 0.
- `start` pulsed in DONE and in WAIT → no state change; `rst` followed by `start` runs a fresh pass.
